sram_march_bist: RTL

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

---
 rtl/sram_march_bist_pkg.sv | 42 ++++
 rtl/sram_march_bist_addr_gen.sv | 40 ++++
 rtl/sram_march_bist.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sram_march_bist_pkg.sv
// Shared types for the SRAM March C- style BIST: FSM states, march elements, read latency.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sram_march_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RW_WR = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } elem_e;

  // Cycles from a read cycle to valid dout.
  localparam int RD_LATENCY = 1;

  // M3 and M4 walk the address space downwards.
  function automatic logic elem_desc(input elem_e e);
    return (e == M3) || (e == M4);
  endfunction

  // Elements whose reads expect all-ones (P1).
  function automatic logic elem_rd_ones(input elem_e e);
    return (e == M2) || (e == M4);
  endfunction

  // Elements whose writes store all-ones (P1).
  function automatic logic elem_wr_ones(input elem_e e);
    return (e == M1) || (e == M3);
  endfunction

endpackage

// File: rtl/sram_march_bist_addr_gen.sv
// Up/down march address counter with end-of-element detect.
// Latency: address advances one clock after step; at_end is combinational.
// Backpressure: none, advances only when step is asserted.
// Ports: init (restart at 0), step, desc (current direction), next_desc (direction
//        of the element that follows a wrap), last (top address), addr, at_end.
module march_addr_gen #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              init,
  input  logic              step,
  input  logic              desc,
  input  logic              next_desc,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] addr,
  output logic              at_end
);

  // Ascending elements end on last, descending ones end on 0 (never underflow).
  assign at_end = desc ? (addr == '0) : (addr == last);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr <= '0;
    end else if (init) begin
      addr <= '0;
    end else if (step) begin
      if (at_end) begin
        // Wrap straight to the first address of the next element.
        addr <= next_desc ? last : '0;
      end else if (desc) begin
        addr <= addr - ADDR_W'(1);
      end else begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_march_bist.sv
// March BIST for one of NUM_SRAMS single-port SRAMs: M0..M5 with P0/P1 patterns.
// Latency: 10N+1 cycles from the cycle after start to DONE; compare 1 cycle after each read.
// Backpressure: none; start is ignored while busy.
// Ports: start/sram_sel/last_addr launch a test; csb/web/wmask/addr/din/dout drive the SRAM;
//        busy/done/fail/err_count/first_fail_addr report status.
module sram_march_bist
  import sram_march_bist_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int WMASK_W   = 4,
  parameter int NUM_SRAMS = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [3:0]           sram_sel,
  input  logic [ADDR_W-1:0]    last_addr,
  input  logic [DATA_W-1:0]    dout,
  output logic [NUM_SRAMS-1:0] csb,
  output logic                 web,
  output logic [WMASK_W-1:0]   wmask,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    din,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [15:0]          err_count,
  output logic [ADDR_W-1:0]    first_fail_addr
);

  state_e            state;
  elem_e             elem;
  elem_e             elem_nxt;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] addr_q;
  logic              at_end;
  logic              start_ok;
  logic              is_wr;
  logic              is_rd;
  logic              active;
  logic              step;
  logic              mismatch;

  // Read pipeline: valid, expected pattern and address travel with each read.
  logic [RD_LATENCY-1:0] rd_vld_p;
  logic [RD_LATENCY-1:0] rd_ones_p;
  logic [ADDR_W-1:0]     rd_addr_p [RD_LATENCY];

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign is_wr    = (state == WR) || (state == RW_WR);
  assign is_rd    = (state == RD);
  assign active   = is_wr || is_rd;
  // M5 is read-only, so its RD cycles advance the address themselves.
  assign step     = is_wr || (is_rd && (elem == M5));
  assign elem_nxt = (elem == M5) ? M5 : elem_e'(elem + 3'd1);

  march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .resetn    (resetn),
    .init      (start_ok),
    .step      (step),
    .desc      (elem_desc(elem)),
    .next_desc (elem_desc(elem_nxt)),
    .last      (last_q),
    .addr      (addr_q),
    .at_end    (at_end)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      elem   <= M0;
      sel_q  <= '0;
      last_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= WR;
            elem   <= M0;
            sel_q  <= sram_sel;
            last_q <= last_addr;
          end
        end
        WR: begin
          if (at_end) begin
            state <= RD;
            elem  <= M1;
          end
        end
        RD: begin
          if (elem == M5) begin
            if (at_end) state <= DRAIN;
          end else begin
            state <= RW_WR;
          end
        end
        RW_WR: begin
          state <= RD;
          if (at_end) elem <= elem_nxt;
        end
        DRAIN:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mismatch = rd_vld_p[RD_LATENCY-1] &&
                    (dout != (rd_ones_p[RD_LATENCY-1] ? {DATA_W{1'b1}} : {DATA_W{1'b0}}));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_vld_p        <= '0;
      rd_ones_p       <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_addr_p[i] <= '0;
      fail            <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
    end else begin
      rd_vld_p[0]  <= is_rd;
      rd_ones_p[0] <= elem_rd_ones(elem);
      rd_addr_p[0] <= addr_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_p[i]  <= rd_vld_p[i-1];
        rd_ones_p[i] <= rd_ones_p[i-1];
        rd_addr_p[i] <= rd_addr_p[i-1];
      end
      if (start_ok) begin
        fail            <= 1'b0;
        err_count       <= '0;
        first_fail_addr <= '0;
      end else if (mismatch) begin
        fail <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (!fail) first_fail_addr <= rd_addr_p[RD_LATENCY-1];
      end
    end
  end

  // SRAM pins are decoded from registered state; an out-of-range select matches no bit.
  always_comb begin
    csb = '1;
    for (int i = 0; i < NUM_SRAMS; i++) begin
      if (active && ({28'd0, sel_q} == 32'(i))) csb[i] = 1'b0;
    end
    web   = !is_wr;
    wmask = is_wr ? {WMASK_W{1'b1}} : {WMASK_W{1'b0}};
    din   = (is_wr && elem_wr_ones(elem)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    addr  = addr_q;
    busy  = active || (state == DRAIN);
    done  = (state == DONE);
  end

endmodule
